// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered RV32I-subset decode stage with one-entry skid buffer
module decode_stage #(
    parameter int XLEN      = 32,
    parameter int PC_W      = 32,
    parameter int ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_insn,
    input  logic [PC_W-1:0]      in_pc,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PC_W-1:0]      out_pc,
    output logic [4:0]           rs1,
    output logic [4:0]           rs2,
    output logic [4:0]           rd,
    output logic [XLEN-1:0]      imm,
    output logic                 reg_we,
    output logic                 mem_we,
    output logic                 mem_re,
    output logic                 alu_src_imm,
    output logic [2:0]           alu_ctr,
    output logic [2:0]           branch_ctr,
    output logic                 illegal,
    output logic [ILL_CNT_W-1:0] illegal_count
);

    localparam logic [2:0] ALU_AND = 3'd0, ALU_OR = 3'd1, ALU_ADD = 3'd2, ALU_SUB = 3'd3, ALU_SLT = 3'd4;
    localparam logic [2:0] BR_NONE = 3'd0, BR_BEQ = 3'd1, BR_BNE = 3'd2, BR_BLT = 3'd3, BR_JAL = 3'd4;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic            reg_we;
        logic            mem_we;
        logic            mem_re;
        logic            alu_src_imm;
        logic [2:0]      alu_ctr;
        logic [2:0]      branch_ctr;
        logic            illegal;
    } beat_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic signed [11:0] i_imm;
    logic signed [11:0] s_imm;
    logic signed [12:0] b_imm;
    logic signed [20:0] j_imm;

    assign opcode = in_insn[6:0];
    assign funct3 = in_insn[14:12];
    assign funct7 = in_insn[31:25];
    assign i_imm  = in_insn[31:20];
    assign s_imm  = {in_insn[31:25], in_insn[11:7]};
    assign b_imm  = {in_insn[31], in_insn[7], in_insn[30:25], in_insn[11:8], 1'b0};
    assign j_imm  = {in_insn[31], in_insn[19:12], in_insn[20], in_insn[30:21], 1'b0};

    beat_t dec;

    // Register fields pass through even for illegal words; only controls and imm are zeroed.
    always_comb begin
        dec         = '0;
        dec.pc      = in_pc;
        dec.rs1     = in_insn[19:15];
        dec.rs2     = in_insn[24:20];
        dec.rd      = in_insn[11:7];
        case (opcode)
            7'b0000011: begin
                if (funct3 == 3'b010) begin
                    dec.reg_we = 1'b1; dec.mem_re = 1'b1; dec.alu_src_imm = 1'b1;
                    dec.alu_ctr = ALU_ADD; dec.imm = XLEN'(i_imm);
                end else dec.illegal = 1'b1;
            end
            7'b0100011: begin
                if (funct3 == 3'b010) begin
                    dec.mem_we = 1'b1; dec.alu_src_imm = 1'b1;
                    dec.alu_ctr = ALU_ADD; dec.imm = XLEN'(s_imm);
                end else dec.illegal = 1'b1;
            end
            7'b0110011: begin
                dec.reg_we = 1'b1;
                case ({funct7, funct3})
                    10'b0000000_111: dec.alu_ctr = ALU_AND;
                    10'b0000000_110: dec.alu_ctr = ALU_OR;
                    10'b0000000_000: dec.alu_ctr = ALU_ADD;
                    10'b0100000_000: dec.alu_ctr = ALU_SUB;
                    10'b0000000_010: dec.alu_ctr = ALU_SLT;
                    default: begin dec.reg_we = 1'b0; dec.illegal = 1'b1; end
                endcase
            end
            7'b0010011: begin
                if (funct3 == 3'b000) begin
                    dec.reg_we = 1'b1; dec.alu_src_imm = 1'b1;
                    dec.alu_ctr = ALU_ADD; dec.imm = XLEN'(i_imm);
                end else dec.illegal = 1'b1;
            end
            7'b1100011: begin
                dec.alu_ctr = ALU_SUB;
                dec.imm     = XLEN'(b_imm);
                case (funct3)
                    3'b000:  dec.branch_ctr = BR_BEQ;
                    3'b001:  dec.branch_ctr = BR_BNE;
                    3'b100:  dec.branch_ctr = BR_BLT;
                    default: begin dec.alu_ctr = ALU_AND; dec.imm = '0; dec.illegal = 1'b1; end
                endcase
            end
            7'b1101111: begin
                dec.reg_we = 1'b1; dec.branch_ctr = BR_JAL; dec.imm = XLEN'(j_imm);
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    beat_t out_q, skid_q;
    logic  out_valid_q, skid_valid_q;
    logic  accept, drain;

    assign in_ready = !skid_valid_q && !flush;
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid_q && out_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (drain) begin
            if (skid_valid_q) begin
                out_q        <= skid_q;
                skid_valid_q <= 1'b0;
            end else if (accept) begin
                out_q <= dec;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (accept) begin
            if (!out_valid_q) begin
                out_q       <= dec;
                out_valid_q <= 1'b1;
            end else begin
                skid_q       <= dec;
                skid_valid_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) illegal_count <= '0;
        else if (drain && out_q.illegal && (illegal_count != '1)) illegal_count <= illegal_count + 1'b1;
    end

    assign out_valid   = out_valid_q;
    assign out_pc      = out_q.pc;
    assign rs1         = out_q.rs1;
    assign rs2         = out_q.rs2;
    assign rd          = out_q.rd;
    assign imm         = out_q.imm;
    assign reg_we      = out_q.reg_we;
    assign mem_we      = out_q.mem_we;
    assign mem_re      = out_q.mem_re;
    assign alu_src_imm = out_q.alu_src_imm;
    assign alu_ctr     = out_q.alu_ctr;
    assign branch_ctr  = out_q.branch_ctr;
    assign illegal     = out_q.illegal;

endmodule
